// File: rtl/tick_period_meter.sv
// Measures the clk-cycle period between consecutive single-cycle ticks and
// presents each result on a valid/ready holding register.
// Optional running minimum of captured periods: define TICK_PERIOD_MIN_EN.
module tick_period_meter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             tick,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    input  logic             ready,
    output logic             overrun,
    output logic             timeout,
    output logic             dbg_state
`ifdef TICK_PERIOD_MIN_EN
    ,
    output logic [WIDTH-1:0] min_period
`endif
);

    generate
        if ((TIMEOUT < 2) || (longint'(TIMEOUT) > ((longint'(1) << WIDTH) - 1))) begin : g_bad_timeout
            $error("tick_period_meter: TIMEOUT out of range 2..2**WIDTH-1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] TIMEOUT_V = WIDTH'(TIMEOUT);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             capture;
    logic             timeout_nxt;

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cnt holds the number of cycles since the last accepted tick; it never
    // passes TIMEOUT because the timeout branch returns to IDLE first.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        capture     = 1'b0;
        timeout_nxt = 1'b0;
        if (!cen) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    if (tick) begin
                        cnt_nxt   = WIDTH'(1);
                        state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    if (tick) begin
                        capture = 1'b1;
                        cnt_nxt = WIDTH'(1);
                    end else if (cnt == TIMEOUT_V) begin
                        timeout_nxt = 1'b1;
                        cnt_nxt     = '0;
                        state_nxt   = IDLE;
                    end else begin
                        cnt_nxt = cnt + WIDTH'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Handshake: a result transfers on any edge where valid && ready. A new
    // capture always wins the register; it flags overrun only when the old
    // result was unread and not being accepted on that same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            period  <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
            timeout <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            timeout <= timeout_nxt;
            overrun <= 1'b0;
            if (capture) begin
                period  <= cnt;
                valid   <= 1'b1;
                overrun <= valid && !ready;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

`ifdef TICK_PERIOD_MIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            min_period <= '1;
        end else if (capture && (cnt < min_period)) begin
            min_period <= cnt;
        end
    end
`endif

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: a cycle-time based reference model (tick
// timestamps, not a counter) checked against the DUT after every edge.
module tb_tick_period_meter;

  localparam int W  = 16;
  localparam int TO = 20;

  logic         clk;
  logic         rst;
  logic         cen;
  logic         tick;
  logic         ready;
  logic [W-1:0] period;
  logic         valid;
  logic         overrun;
  logic         timeout;
  logic         dbg_state;
`ifdef TICK_PERIOD_MIN_EN
  logic [W-1:0] min_period;
`endif

  tick_period_meter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .tick      (tick),
    .period    (period),
    .valid     (valid),
    .ready     (ready),
    .overrun   (overrun),
    .timeout   (timeout),
    .dbg_state (dbg_state)
`ifdef TICK_PERIOD_MIN_EN
    ,
    .min_period(min_period)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: remembers the cycle of the last tick while armed
  int           cyc = 0;
  bit           armed = 0;
  int           last = 0;
  logic [W-1:0] m_period = '0;
  bit           m_valid = 0;
  bit           m_ov = 0;
  bit           m_to = 0;
  logic [W-1:0] m_min = '1;

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           total = 0;
  int           bad = 0;
  int           ov_cnt = 0;
  int           to_cnt = 0;
  int           to_cyc = 0;
  int           last_tick_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, req, cyc);
    end
  endtask

  task automatic model_edge();
    bit cap;
    int capv;
    cyc++;
    cap  = 0;
    capv = 0;
    if (rst) begin
      armed    = 0;
      m_period = '0;
      m_valid  = 0;
      m_ov     = 0;
      m_to     = 0;
      m_min    = '1;
    end else begin
      m_ov = 0;
      m_to = 0;
      if (!cen) begin
        armed = 0;
      end else if (tick) begin
        if (armed) begin
          cap  = 1;
          capv = cyc - last;
        end
        armed         = 1;
        last          = cyc;
        last_tick_cyc = cyc;
      end else if (armed && (cyc - last == TO)) begin
        m_to  = 1;
        armed = 0;
      end
      if (cap) begin
        m_ov     = m_valid && !ready;
        m_period = W'(capv);
        m_valid  = 1;
        if (W'(capv) < m_min) m_min = W'(capv);
      end else if (m_valid && ready) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("period", period, m_period);
    chk("valid", valid, m_valid);
    chk("overrun", overrun, m_ov);
    chk("timeout", timeout, m_to);
    chk("state", dbg_state, armed);
`ifdef TICK_PERIOD_MIN_EN
    chk("min_period", min_period, m_min);
`endif
  endtask

  // driver: inputs change at negedge, model and compare follow each posedge
  task automatic step(input logic c, input logic t, input logic r, input logic rs);
    @(negedge clk);
    cen   = c;
    tick  = t;
    ready = r;
    rst   = rs;
    if (valid && ready && !rst) got_q.push_back(period);
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (overrun) ov_cnt++;
    if (timeout) begin
      to_cnt++;
      to_cyc = cyc;
    end
  endtask

  task automatic pulse_train(input int n, input int gap, input logic r);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, r, 1'b0);
      if (i != n - 1)
        for (int j = 0; j < gap - 1; j++) step(1'b1, 1'b0, r, 1'b0);
    end
  endtask

  task automatic check_results(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({name, "_value"}, got_q[i], exp_q[i]);
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int ov0;
    int to0;
    int gaps[3];
    int dens;
    rst   = 1'b1;
    cen   = 1'b0;
    tick  = 1'b0;
    ready = 1'b0;

    // reset state
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_period", period, 0);
    chk("rst_valid", valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_state", dbg_state, 0);
    got_q.delete();

    // ticks every 16th cycle, consumer always ready
    ov0 = ov_cnt;
    pulse_train(5, 16, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) exp_q.push_back(16);
    check_results("every16");
    chk("every16_overruns", ov_cnt - ov0, 0);

    // tick held high four cycles
    pulse_train(4, 1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) exp_q.push_back(1);
    check_results("back2back");

    // unread result overwritten, then accepted
    ov0 = ov_cnt;
    pulse_train(2, 10, 1'b0);
    chk("ovr_first_period", period, 10);
    repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("ovr_period", period, 7);
    chk("ovr_valid", valid, 1);
    chk("ovr_pulse", overrun, 1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("ovr_valid_drop", valid, 0);
    chk("ovr_period_held", period, 7);
    chk("ovr_pulses", ov_cnt - ov0, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(7);
    check_results("overrun");

    // timeout after one tick, then re-arm
    to0 = to_cnt;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (25) step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("to_pulses", to_cnt - to0, 1);
    chk("to_delay", to_cyc - last_tick_cyc, TO);
    chk("to_valid", valid, 0);
    chk("to_state", dbg_state, 0);
    pulse_train(2, 5, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(5);
    check_results("rearm");

    // cen gap mid-measurement with a tick inside the gap
    step(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (8) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("cen_state", dbg_state, 0);
    pulse_train(2, 6, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(6);
    check_results("cen_gap");

    // running minimum over 16, 7, 12
    step(1'b0, 1'b0, 1'b1, 1'b1);
    gaps = '{16, 7, 12};
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      repeat (gaps[i] - 1) step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      exp_q.push_back(W'(gaps[i]));
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_results("minseq");
`ifdef TICK_PERIOD_MIN_EN
    chk("min_value", min_period, 7);
`endif

    // reset while holding an unread result mid-measurement
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("prerst_valid", valid, 1);
    chk("prerst_period", period, 4);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("midrst_period", period, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_state", dbg_state, 0);
`ifdef TICK_PERIOD_MIN_EN
    chk("midrst_min", min_period, 32'hFFFF);
`endif

    // randomized traffic, checked every cycle by the model
    dens = 4;
    for (int k = 0; k < 4000; k++) begin
      if (k % 200 == 0) dens = $urandom_range(0, 30);
      step($urandom_range(0, 19) != 0, $urandom_range(0, dens) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 499) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_period_meter.md
Name: tick_period_meter

Overview:
- Consumer end of the counter-overflow strobe path: takes a single-cycle tick stream, such as a mod counter's sync_ovf, and measures the clk-cycle period between consecutive ticks.
- Presents each measurement on a valid/ready output holding register, so a UART or debug logger can read measured rates.
- Flags lost results (overrun) and missing ticks (timeout).

Parameters:
- WIDTH, 16, width of the period counter and the period output.
- TIMEOUT, 65535, cycles without a tick before timeout; legal range 2 to 2**WIDTH-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cen  input  1  block enable; low forces the measurement back to idle.
- tick  input  1  strobe, sampled every cycle; each high cycle is one tick.
- period  output  WIDTH  last captured period in clk cycles.
- valid  output  1  period holds an unread result.
- ready  input  1  consumer accepts period when valid and ready are both high.
- overrun  output  1  one-cycle pulse: an unread result was overwritten.
- timeout  output  1  one-cycle pulse: no tick within TIMEOUT cycles.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, cnt=0, period=0, valid=0, overrun=0, timeout=0.
  - rst overrides cen, tick and ready, including mid-measurement.
- State IDLE:
  - cnt held at 0.
  - tick && cen: cnt<=1, go to MEASURE. No capture, because there is no previous tick.
- State MEASURE, cen=1, evaluated each cycle:
  - tick=1: capture cnt into the holding register, cnt<=1, stay in MEASURE.
  - tick=0 and cnt==TIMEOUT: timeout=1 for one cycle, cnt<=0, go to IDLE, no capture.
  - Otherwise: cnt<=cnt+1.
- Period definition:
  - Ticks at cycles t0 and t1 give period = t1-t0.
  - Tick high on consecutive cycles gives period = 1.
  - Tick every 16th cycle gives 16.
- cen=0 in any state:
  - Go to IDLE with cnt<=0. Ticks are ignored; no timeout fires.
  - Holding register, valid and handshake are unaffected.
- Latency: period and valid update at the edge that samples the closing tick, i.e. visible in the following cycle.
- Handshake:
  - valid stays 1 and period stays stable until a cycle with valid && ready.
  - Accept with no new capture in the same cycle: valid<=0; period keeps its old value.
  - Capture while valid=1 and ready=0: period is overwritten, valid stays 1, overrun=1 for that next cycle.
  - Capture in the same cycle as an accept: new value loaded, valid stays 1, no overrun.
  - Capture while valid=0: load, valid<=1.
- Width: cnt never exceeds TIMEOUT, so there is no wrap. TIMEOUT outside the legal range is a parameter error, checked by a generate-time $error.

Optional Feature:
- Macro: TICK_PERIOD_MIN_EN.
- When defined:
  - Adds output min_period (WIDTH), reset to all ones.
  - On every capture, min_period <= min(min_period, captured value); dropped and overwritten results still count.
  - Unaffected by cen and timeout; only rst restores it.
- When undefined: the port and its register are absent, and the rest of the behaviour is identical.

Test Plan:
- rst 1 cycle, cen=1, ready=1, tick every 16th cycle for 5 ticks → first tick gives no valid; then 4 results of period=16, valid high for one cycle each, overrun never 1.
- Tick held high 4 consecutive cycles, ready=1 → results 1,1,1, valid the cycle after ticks 2, 3 and 4.
- ready=0, ticks every 10 then after 7 cycles → period=10, valid=1; then period=7, overrun pulses once, valid stays 1. Raise ready → valid drops the next cycle.
- TIMEOUT=20, one tick then none for 25 cycles → timeout pulses exactly once, 20 cycles after the tick; valid stays 0; next two ticks 5 apart → period=5, no capture for the tick that re-arms.
- cen=0 for 3 cycles mid-measurement (cnt=9), tick during cen=0, cen=1, ticks 6 apart → no capture across the gap; then period=6. With TICK_PERIOD_MIN_EN, periods 16,7,12 → min_period=7.
- rst asserted with valid=1 and cnt=5 → next cycle period=0, valid=0, state IDLE, min_period=all ones if the macro is enabled.
